// File: rtl/vram_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter_rr
// Description : Multi-port VRAM front end. NUM_PORTS requesters share one
//               single-port word RAM. Port 0 may write; the other ports
//               only read. Arbitration is either fixed TDM slots or
//               work-conserving round-robin. Read latency is 1 or 2 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter_rr #(
    parameter int NUM_PORTS       = 4,
    parameter int ADDR_W          = 15,
    parameter int DATA_W          = 32,
    parameter int VRAM_SIZE_BYTES = 131072,
    parameter int RD_LATENCY      = 1,
    parameter int ARB_MODE        = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            p0_wrdata,
    input  logic [DATA_W/8-1:0]          p0_wrbytesel,
    input  logic                         p0_write,
    input  logic [NUM_PORTS-1:0]         strobe,
    input  logic [NUM_PORTS*ADDR_W-1:0]  addr,
    output logic [NUM_PORTS-1:0]         ack,
    output logic [DATA_W-1:0]            rddata,
    output logic [$clog2(NUM_PORTS)-1:0] grant_port,
    output logic                         grant_valid
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = VRAM_SIZE_BYTES / NB;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PW    = $clog2(NUM_PORTS);
    localparam logic [PW-1:0] C_LAST_PORT = PW'(NUM_PORTS - 1);

    logic [NUM_PORTS-1:0] pending_q, pending_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]        slot_q, slot_d;
    logic [NUM_PORTS-1:0] ack1_q;
    logic [NUM_PORTS-1:0] ack_last;
    logic [DATA_W-1:0]    rd1_q;
    logic [DATA_W-1:0]    rd_last;

    logic [NUM_PORTS-1:0] w_elig;
    logic [NUM_PORTS-1:0] w_gnt_oh;
    logic                 w_gnt_valid;
    logic [PW-1:0]        w_gnt_port;
    logic [ADDR_W-1:0]    w_addr;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_we;

    logic [DATA_W-1:0]    mem [DEPTH];

    // Pick at most one eligible port this cycle; nothing is granted while in reset.
    always_comb begin
        int idx;
        w_elig      = strobe & ~pending_q;
        w_gnt_valid = 1'b0;
        w_gnt_port  = '0;
        w_gnt_oh    = '0;
        idx         = 0;
        if (!rst) begin
            if (ARB_MODE == 0) begin
                if (w_elig[slot_q]) begin
                    w_gnt_valid = 1'b1;
                    w_gnt_port  = slot_q;
                end
            end else begin
                // Descending scan so the last hit is the closest port at or after rr_ptr.
                for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                    idx = int'(rr_ptr_q) + k;
                    if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
                    if (w_elig[idx]) begin
                        w_gnt_valid = 1'b1;
                        w_gnt_port  = PW'(idx);
                    end
                end
            end
            if (w_gnt_valid) w_gnt_oh[w_gnt_port] = 1'b1;
        end
    end

    assign w_addr = addr[int'(w_gnt_port)*ADDR_W +: ADDR_W];
    assign w_idx  = w_addr[IDX_W-1:0];
    assign w_we   = w_gnt_valid && (w_gnt_port == '0) && p0_write && !rst;

    // Upper address bits beyond the RAM depth alias onto the low words.
    if (ADDR_W > IDX_W) begin : g_alias
        logic w_unused_hi;
        assign w_unused_hi = ^w_addr[ADDR_W-1:IDX_W];
    end

    // Next-state for pending flags, round-robin pointer and TDM slot counter.
    always_comb begin
        pending_d = (pending_q & ~ack_last) | w_gnt_oh;
        rr_ptr_d  = rr_ptr_q;
        if ((ARB_MODE != 0) && w_gnt_valid)
            rr_ptr_d = (w_gnt_port == C_LAST_PORT) ? '0 : w_gnt_port + 1'b1;
        slot_d = (slot_q == C_LAST_PORT) ? '0 : slot_q + 1'b1;
    end

    // Arbiter state and first ack stage; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            rr_ptr_q  <= '0;
            slot_q    <= '0;
            ack1_q    <= '0;
        end else begin
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            slot_q    <= slot_d;
            ack1_q    <= w_gnt_oh;
        end
    end

    // Single-port RAM: byte-masked write from port 0, registered read on every grant.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < NB; b++) begin
                if (p0_wrbytesel[b]) mem[w_idx][b*8 +: 8] <= p0_wrdata[b*8 +: 8];
            end
        end
        if (w_gnt_valid) rd1_q <= mem[w_idx];
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [NUM_PORTS-1:0] ack2_q;
        logic [DATA_W-1:0]    rd2_q;

        // Extra ack stage aligned with the RAM output register.
        always_ff @(posedge clk) begin
            if (rst) ack2_q <= '0;
            else     ack2_q <= ack1_q;
        end

        // RAM output register stage; content needs no reset.
        always_ff @(posedge clk) begin
            rd2_q <= rd1_q;
        end

        assign ack_last = ack2_q;
        assign rd_last  = rd2_q;
    end else begin : g_lat1
        assign ack_last = ack1_q;
        assign rd_last  = rd1_q;
    end

    // An ack already in the pipe when reset rises must not escape.
    assign ack         = ack_last & {NUM_PORTS{~rst}};
    assign rddata      = rd_last;
    assign grant_port  = w_gnt_port;
    assign grant_valid = w_gnt_valid;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_arbiter_rr
// Description : Self-checking bench for vram_arbiter_rr. Three instances:
//               RR/latency 1, TDM/latency 1, and 6-port RR/latency 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter_rr;

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [31:0] p0_wrdata = '0;
    logic [3:0]  p0_wrbytesel = '0;
    logic        p0_write = 1'b0;

    logic [3:0]  strobe_a = '0;
    logic [59:0] addr_a = '0;
    logic [3:0]  ack_a;
    logic [31:0] rddata_a;
    logic [1:0]  gp_a;
    logic        gv_a;

    logic [3:0]  strobe_t = '0;
    logic [3:0]  ack_t;
    logic [31:0] rddata_t;
    logic [1:0]  gp_t;
    logic        gv_t;

    logic [5:0]  strobe_s = '0;
    logic [95:0] addr_s = '0;
    logic [5:0]  ack_s;
    logic [31:0] rddata_s;
    logic [2:0]  gp_s;
    logic        gv_s;

    int n_cmp = 0;
    int n_err = 0;

    exp_t        sb[$];
    logic [31:0] model_mem [int];

    vram_arbiter_rr #(.NUM_PORTS(4), .ADDR_W(15), .RD_LATENCY(1), .ARB_MODE(1)) dut (
        .clk(clk), .rst(rst), .p0_wrdata(p0_wrdata), .p0_wrbytesel(p0_wrbytesel),
        .p0_write(p0_write), .strobe(strobe_a), .addr(addr_a), .ack(ack_a),
        .rddata(rddata_a), .grant_port(gp_a), .grant_valid(gv_a));

    vram_arbiter_rr #(.NUM_PORTS(4), .ADDR_W(15), .RD_LATENCY(1), .ARB_MODE(0)) dut_tdm (
        .clk(clk), .rst(rst), .p0_wrdata(p0_wrdata), .p0_wrbytesel(p0_wrbytesel),
        .p0_write(p0_write), .strobe(strobe_t), .addr(addr_a), .ack(ack_t),
        .rddata(rddata_t), .grant_port(gp_t), .grant_valid(gv_t));

    vram_arbiter_rr #(.NUM_PORTS(6), .ADDR_W(16), .RD_LATENCY(2), .ARB_MODE(1)) dut6 (
        .clk(clk), .rst(rst), .p0_wrdata(p0_wrdata), .p0_wrbytesel(p0_wrbytesel),
        .p0_write(p0_write), .strobe(strobe_s), .addr(addr_s), .ack(ack_s),
        .rddata(rddata_s), .grant_port(gp_s), .grant_valid(gv_s));

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_write(int a, logic [31:0] d, logic [3:0] sel);
        logic [31:0] v;
        v = model_mem.exists(a) ? model_mem[a] : 32'h0;
        for (int b = 0; b < 4; b++) if (sel[b]) v[b*8 +: 8] = d[b*8 +: 8];
        model_mem[a] = v;
    endfunction

    // Port 0 write on the main instance; ok reports whether ack[0] arrived.
    task automatic do_write(input logic [14:0] a, input logic [31:0] d,
                            input logic [3:0] sel, output bit ok);
        ok = 1'b0;
        addr_a[14:0] = a;
        p0_wrdata = d;
        p0_wrbytesel = sel;
        p0_write = 1'b1;
        strobe_a[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ack_a[0]) begin
                ok = 1'b1;
                break;
            end
        end
        strobe_a[0] = 1'b0;
        p0_write = 1'b0;
        model_write(int'(a), d, sel);
    endtask

    // Read on the main instance from port p; returns data seen with the ack.
    task automatic do_read(input int p, input logic [14:0] a,
                           output bit ok, output logic [31:0] d);
        ok = 1'b0;
        d = 'x;
        addr_a[p*15 +: 15] = a;
        strobe_a[p] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ack_a[p]) begin
                ok = 1'b1;
                d = rddata_a;
                break;
            end
        end
        strobe_a[p] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        strobe_a = 4'hF;
        strobe_t = 4'hF;
        strobe_s = 6'h3F;
        tick();
        tick();
        tick();
        n_cmp++; if (ack_a !== 4'b0) begin n_err++; $display("FAIL reset_ack: got %b expected %b", ack_a, 4'b0); end
        n_cmp++; if (gv_a !== 1'b0) begin n_err++; $display("FAIL reset_gv: got %b expected 0", gv_a); end
        n_cmp++; if (gp_a !== 2'd0) begin n_err++; $display("FAIL reset_gp: got %0d expected 0", gp_a); end
        n_cmp++; if (gv_t !== 1'b0) begin n_err++; $display("FAIL reset_gv_tdm: got %b expected 0", gv_t); end
        n_cmp++; if (ack_s !== 6'b0) begin n_err++; $display("FAIL reset_ack6: got %b expected %b", ack_s, 6'b0); end
        strobe_a = '0;
        strobe_t = '0;
        strobe_s = '0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rr_all();
        bit   ok;
        int   nack;
        int   last_c[4];
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            do_write(15'h100 + 15'(i), 32'hA000_0000 + 32'(i) * 32'h1111, 4'hF, ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL rr_init_write%0d: got no ack expected ack", i); end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr_a[i*15 +: 15] = 15'h100 + 15'(i);
            last_c[i] = -1;
        end
        for (int i = 0; i < 8; i++) sb.push_back('{i % 4, model_mem[32'h100 + i % 4]});
        strobe_a = 4'hF;
        #1;
        n_cmp++; if (gv_a !== 1'b1 || gp_a !== 2'd0) begin n_err++; $display("FAIL rr_first_grant: got v=%b p=%0d expected v=1 p=0", gv_a, gp_a); end
        nack = 0;
        for (int c = 0; c < 40 && nack < 8; c++) begin
            tick();
            if (ack_a != 4'b0) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL rr_extra_ack: got %b expected none", ack_a);
                end else begin
                    e = sb.pop_front();
                    n_cmp++; if (ack_a !== 4'(1 << e.port)) begin n_err++; $display("FAIL rr_ack_order: got %b expected port %0d", ack_a, e.port); end
                    n_cmp++; if (rddata_a !== e.data) begin n_err++; $display("FAIL rr_data: got %h expected %h", rddata_a, e.data); end
                    if (last_c[e.port] >= 0) begin
                        n_cmp++; if (c - last_c[e.port] != 4) begin n_err++; $display("FAIL rr_spacing: got %0d expected 4", c - last_c[e.port]); end
                    end
                    last_c[e.port] = c;
                    nack++;
                end
                if (nack == 8) strobe_a = 4'b0;
            end
        end
        strobe_a = 4'b0;
        n_cmp++; if (nack != 8) begin n_err++; $display("FAIL rr_timeout: got %0d acks expected 8", nack); end
        sb.delete();
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (ack_a !== 4'b0) begin n_err++; $display("FAIL rr_stray_ack: got %b expected 0000", ack_a); end
        end
    endtask

    task automatic test_single_port();
        int cnt_a, cnt_t, last_a, last_t;
        cnt_a = 0; cnt_t = 0; last_a = -1; last_t = -1;
        addr_a[2*15 +: 15] = 15'h102;
        strobe_a = 4'b0100;
        strobe_t = 4'b0100;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (ack_a[2]) begin
                if (last_a >= 0) begin
                    n_cmp++; if (c - last_a != 2) begin n_err++; $display("FAIL single_rr_spacing: got %0d expected 2", c - last_a); end
                end
                n_cmp++; if (rddata_a !== model_mem[32'h102]) begin n_err++; $display("FAIL single_rr_data: got %h expected %h", rddata_a, model_mem[32'h102]); end
                last_a = c;
                cnt_a++;
            end
            if (ack_t[2]) begin
                if (last_t >= 0) begin
                    n_cmp++; if (c - last_t != 4) begin n_err++; $display("FAIL single_tdm_spacing: got %0d expected 4", c - last_t); end
                end
                last_t = c;
                cnt_t++;
            end
        end
        strobe_a = 4'b0;
        strobe_t = 4'b0;
        n_cmp++; if (cnt_a != 6) begin n_err++; $display("FAIL single_rr_count: got %0d expected 6", cnt_a); end
        n_cmp++; if (cnt_t != 3) begin n_err++; $display("FAIL single_tdm_count: got %0d expected 3", cnt_t); end
        for (int c = 0; c < 3; c++) tick();
    endtask

    task automatic test_byte_enable();
        bit          ok;
        logic [31:0] d;
        exp_t        e;
        int          t0, t1;
        do_write(15'h10, 32'h1234_0000, 4'hF, ok);
        do_write(15'h10, 32'hDEAD_BEEF, 4'b0011, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL be_write_ack: got no ack expected ack"); end
        sb.push_back('{1, 32'h1234_BEEF});
        do_read(1, 15'h10, ok, d);
        e = sb.pop_front();
        n_cmp++; if (!ok || d !== e.data) begin n_err++; $display("FAIL be_partial: got %h expected %h", d, e.data); end
        do_write(15'h10, 32'hFFFF_FFFF, 4'b0000, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL be_zero_sel_ack: got no ack expected ack"); end
        sb.push_back('{2, model_mem[32'h10]});
        do_read(2, 15'h10, ok, d);
        e = sb.pop_front();
        n_cmp++; if (!ok || d !== e.data) begin n_err++; $display("FAIL be_zero_sel: got %h expected %h", d, e.data); end
        // Read-after-write: port 0 write granted, port 1 read granted next cycle.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        addr_a[14:0] = 15'h20;
        addr_a[15 +: 15] = 15'h20;
        p0_wrdata = 32'hCAFE_F00D;
        p0_wrbytesel = 4'hF;
        p0_write = 1'b1;
        model_write(32'h20, 32'hCAFE_F00D, 4'hF);
        sb.push_back('{1, model_mem[32'h20]});
        strobe_a = 4'b0011;
        t0 = -1; t1 = -1;
        for (int c = 0; c < 10 && strobe_a != 4'b0; c++) begin
            tick();
            if (ack_a[0]) begin
                t0 = c;
                strobe_a[0] = 1'b0;
                p0_write = 1'b0;
            end
            if (ack_a[1]) begin
                t1 = c;
                e = sb.pop_front();
                n_cmp++; if (rddata_a !== e.data) begin n_err++; $display("FAIL raw_data: got %h expected %h", rddata_a, e.data); end
                strobe_a[1] = 1'b0;
            end
        end
        strobe_a = 4'b0;
        p0_write = 1'b0;
        n_cmp++; if (t0 != 0 || t1 != 1) begin n_err++; $display("FAIL raw_timing: got ack0@%0d ack1@%0d expected ack0@0 ack1@1", t0, t1); end
        sb.delete();
        tick();
    endtask

    task automatic test_reset_inflight();
        bit   ok;
        int   nack;
        exp_t e;
        do_write(15'h40, 32'h1111_1111, 4'hF, ok);
        addr_a[3*15 +: 15] = 15'h40;
        strobe_a = 4'b1000;
        #1;
        n_cmp++; if (gv_a !== 1'b1 || gp_a !== 2'd3) begin n_err++; $display("FAIL rst_pre_grant: got v=%b p=%0d expected v=1 p=3", gv_a, gp_a); end
        tick();
        rst = 1'b1;
        addr_a[14:0] = 15'h40;
        p0_wrdata = 32'hA5A5_A5A5;
        p0_wrbytesel = 4'hF;
        p0_write = 1'b1;
        strobe_a = 4'b1001;
        #1;
        n_cmp++; if (ack_a !== 4'b0) begin n_err++; $display("FAIL rst_ack_dropped: got %b expected 0000", ack_a); end
        n_cmp++; if (gv_a !== 1'b0) begin n_err++; $display("FAIL rst_no_grant: got %b expected 0", gv_a); end
        tick();
        rst = 1'b0;
        p0_write = 1'b0;
        addr_a[2*15 +: 15] = 15'h40;
        strobe_a = 4'b1100;
        sb.push_back('{2, model_mem[32'h40]});
        sb.push_back('{3, model_mem[32'h40]});
        #1;
        n_cmp++; if (ack_a !== 4'b0) begin n_err++; $display("FAIL rst_pipe_clear: got %b expected 0000", ack_a); end
        n_cmp++; if (gv_a !== 1'b1 || gp_a !== 2'd2) begin n_err++; $display("FAIL rst_first_grant: got v=%b p=%0d expected v=1 p=2", gv_a, gp_a); end
        nack = 0;
        for (int c = 0; c < 10 && nack < 2; c++) begin
            tick();
            for (int p = 0; p < 4; p++) begin
                if (ack_a[p]) begin
                    e = sb.pop_front();
                    n_cmp++; if (p != e.port || rddata_a !== e.data) begin n_err++; $display("FAIL rst_write_absent: got port %0d data %h expected port %0d data %h", p, rddata_a, e.port, e.data); end
                    strobe_a[p] = 1'b0;
                    nack++;
                end
            end
        end
        strobe_a = 4'b0;
        n_cmp++; if (nack != 2) begin n_err++; $display("FAIL rst_read_timeout: got %0d acks expected 2", nack); end
        sb.delete();
        tick();
    endtask

    task automatic test_latency2_six_ports();
        int   got;
        exp_t e;
        int   exp_seq[4];
        exp_seq = '{0, 4, 5, 0};
        // Write word 0x10 on the 6-port instance; ack must be two cycles after grant.
        addr_s[15:0] = 16'h0010;
        p0_wrdata = 32'h5566_7788;
        p0_wrbytesel = 4'hF;
        p0_write = 1'b1;
        strobe_s = 6'b000001;
        got = -1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ack_s[0]) begin got = c; break; end
        end
        strobe_s = '0;
        p0_write = 1'b0;
        n_cmp++; if (got != 1) begin n_err++; $display("FAIL lat2_write_ack: got tick %0d expected tick 1", got); end
        // Alias: 0x8010 maps onto word 0x0010 of a 32768-word RAM.
        sb.push_back('{3, 32'h5566_7788});
        addr_s[3*16 +: 16] = 16'h8010;
        strobe_s = 6'b001000;
        got = -1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ack_s[3]) begin
                got = c;
                e = sb.pop_front();
                n_cmp++; if (rddata_s !== e.data) begin n_err++; $display("FAIL alias_data: got %h expected %h", rddata_s, e.data); end
                break;
            end
        end
        strobe_s = '0;
        n_cmp++; if (got != 1) begin n_err++; $display("FAIL alias_ack: got tick %0d expected tick 1", got); end
        tick();
        tick();
        // Held strobe on port 1: no re-grant while the ack is still in flight.
        addr_s[16 +: 16] = 16'h0010;
        strobe_s = 6'b000010;
        #1;
        n_cmp++; if (gv_s !== 1'b1 || gp_s !== 3'd1) begin n_err++; $display("FAIL lat2_grant: got v=%b p=%0d expected v=1 p=1", gv_s, gp_s); end
        tick();
        n_cmp++; if (ack_s !== 6'b0 || gv_s !== 1'b0) begin n_err++; $display("FAIL lat2_t1: got ack=%b v=%b expected ack=000000 v=0", ack_s, gv_s); end
        tick();
        n_cmp++; if (ack_s !== 6'b000010 || rddata_s !== 32'h5566_7788) begin n_err++; $display("FAIL lat2_t2: got ack=%b data=%h expected ack=000010 data=55667788", ack_s, rddata_s); end
        n_cmp++; if (gv_s !== 1'b0) begin n_err++; $display("FAIL lat2_ack_cycle_grant: got %b expected 0", gv_s); end
        tick();
        n_cmp++; if (gv_s !== 1'b1 || gp_s !== 3'd1) begin n_err++; $display("FAIL lat2_regrant: got v=%b p=%0d expected v=1 p=1", gv_s, gp_s); end
        strobe_s = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (ack_s !== 6'b0) begin n_err++; $display("FAIL lat2_stray_ack: got %b expected 000000", ack_s); end
        end
        // rr_ptr wrap 5 -> 0 with ports 0, 4 and 5 requesting.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        strobe_s = 6'b110001;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (gv_s !== 1'b1 || int'(gp_s) != exp_seq[k]) begin n_err++; $display("FAIL wrap_seq%0d: got v=%b p=%0d expected v=1 p=%0d", k, gv_s, gp_s, exp_seq[k]); end
            tick();
        end
        strobe_s = '0;
        sb.delete();
        for (int c = 0; c < 4; c++) tick();
    endtask

    initial begin
        test_reset();
        test_rr_all();
        test_single_port();
        test_byte_enable();
        test_reset_inflight();
        test_latency2_six_ports();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
